gppcu_cmd_frontend: RTL and testbench

- Parametrised host-command front end for the GPPCU core, fully synchronous to opclk.
- Decodes one command word per cycle into these operations:
  - instruction-FIFO push
  - thread local-memory read/write
  - global-memory write
  - FIFO flush
  - status read
  - error clear
- The first-word-fall-through instruction FIFO feeds the core over a valid/ready handshake, with exact full/almost-full/level reporting and sticky error flags.

---
 rtl/gppcu_cmd_pkg.sv | 28 ++
 rtl/gppcu_fwft_fifo.sv | 77 +++++++
 rtl/gppcu_cmd_frontend.sv | 181 ++++++++++++++++++
 tb/tb_gppcu_cmd_frontend.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gppcu_cmd_pkg.sv
// gppcu_cmd_pkg: shared definitions for the GPPCU host-command front end.
// Contents: command opcodes, status-word bit positions and the read-FSM state encoding.
package gppcu_cmd_pkg;

    localparam int unsigned OP_W = 7;

    localparam logic [OP_W-1:0] OP_PUSH   = 7'd0;
    localparam logic [OP_W-1:0] OP_RDL    = 7'd1;
    localparam logic [OP_W-1:0] OP_WRL    = 7'd2;
    localparam logic [OP_W-1:0] OP_WRG    = 7'd3;
    localparam logic [OP_W-1:0] OP_FLUSH  = 7'd4;
    localparam logic [OP_W-1:0] OP_STATUS = 7'd5;
    localparam logic [OP_W-1:0] OP_CLRERR = 7'd6;

    // Status word layout; the FIFO level occupies the low bits.
    localparam int unsigned ST_OVF_BIT    = 31;
    localparam int unsigned ST_BADCMD_BIT = 30;
    localparam int unsigned ST_FULL_BIT   = 29;
    localparam int unsigned ST_EMPTY_BIT  = 28;

    typedef enum logic [1:0] {
        StIdle,
        StRdIssue,
        StRdWait,
        StRdDone
    } fe_state_e;

endpackage

// File: rtl/gppcu_fwft_fifo.sv
// gppcu_fwft_fifo: first-word-fall-through instruction FIFO.
// Ports:
//   opclk, inRST        clock, asynchronous active-low reset
//   push, wdata         write request; refused (ovf pulse) when full
//   pop                 consume head; ignored when empty or flushing
//   flush               clear pointers and level
//   rdata               head word, combinational from storage
//   level/full/empty/afull  occupancy status from the registered count
//   ovf                 one-cycle pulse when a push hits a full FIFO
module gppcu_fwft_fifo
    import gppcu_cmd_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned DEPTH_LOG2   = 8,
    parameter int unsigned AFULL_MARGIN = 4
) (
    input  logic                  opclk,
    input  logic                  inRST,
    input  logic                  push,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  pop,
    input  logic                  flush,
    output logic [DATA_W-1:0]     rdata,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  empty,
    output logic                  afull,
    output logic                  ovf
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_L = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] head_q, tail_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic [DEPTH_LOG2:0]   free_cnt;
    logic                  push_ok, pop_ok;

    assign full     = (count_q == DEPTH_L);
    assign empty    = (count_q == '0);
    assign level    = count_q;
    assign free_cnt = DEPTH_L - count_q;
    assign afull    = (32'(free_cnt) <= AFULL_MARGIN);
    assign rdata    = mem[tail_q];

    // Fullness comes from the registered count only, so a same-cycle pop never frees a slot.
    assign push_ok = push & ~full;
    assign ovf     = push & full;
    assign pop_ok  = pop & ~empty & ~flush;

    always_ff @(posedge opclk or negedge inRST) begin
        if (!inRST) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) head_q <= head_q + 1'b1;
            if (pop_ok)  tail_q <= tail_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge opclk) begin
        if (push_ok) mem[head_q] <= wdata;
    end

endmodule

// File: rtl/gppcu_cmd_frontend.sv
// gppcu_cmd_frontend: host-command decoder for the GPPCU core.
// Ports:
//   opclk, inRST                      clock, asynchronous active-low reset
//   iCMD_*, iDATA, oCMD_READY         command interface (accept = valid & ready)
//   oINSTR*, iINSTR_READY             FWFT instruction stream to the core
//   oLEVEL, oFULL, oALMOST_FULL, oEMPTY  FIFO status
//   oERR_OVF, oERR_BADCMD             sticky error flags, cleared by CLRERR
//   oLMEM_*, iLMEM_RDATA              thread local-memory port (read data 1 cycle after rd)
//   oGMEM_*                           global-memory write port
//   oDATA, oDATA_VALID                read / status result
module gppcu_cmd_frontend
    import gppcu_cmd_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned DEPTH_LOG2   = 8,
    parameter int unsigned THREAD_W     = 8,
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned AFULL_MARGIN = 4
) (
    input  logic                opclk,
    input  logic                inRST,
    input  logic                iCMD_VALID,
    input  logic [OP_W-1:0]     iCMD_OP,
    input  logic [THREAD_W-1:0] iCMD_THREAD,
    input  logic [ADDR_W-1:0]   iCMD_ADDR,
    input  logic [DATA_W-1:0]   iDATA,
    output logic                oCMD_READY,
    output logic [DATA_W-1:0]   oINSTR,
    output logic                oINSTR_VALID,
    input  logic                iINSTR_READY,
    output logic [DEPTH_LOG2:0] oLEVEL,
    output logic                oFULL,
    output logic                oALMOST_FULL,
    output logic                oEMPTY,
    output logic                oERR_OVF,
    output logic                oERR_BADCMD,
    output logic [THREAD_W-1:0] oLMEM_THREAD,
    output logic [ADDR_W-1:0]   oLMEM_ADDR,
    output logic [DATA_W-1:0]   oLMEM_WDATA,
    output logic                oLMEM_RD,
    output logic                oLMEM_WR,
    input  logic [DATA_W-1:0]   iLMEM_RDATA,
    output logic [ADDR_W-1:0]   oGMEM_ADDR,
    output logic [DATA_W-1:0]   oGMEM_WDATA,
    output logic                oGMEM_WR,
    output logic [DATA_W-1:0]   oDATA,
    output logic                oDATA_VALID
);

    fe_state_e         state_q;
    logic              ready_q, lmem_rd_q, data_valid_q;
    logic [DATA_W-1:0] data_q;
    logic              lmem_wr_q, gmem_wr_q, ovf_q, badcmd_q;
    logic              accept, is_push, is_rdl, is_wrl, is_wrg, is_flush, is_status;
    logic              is_clrerr, is_bad, fifo_ovf;
    logic [DATA_W-1:0] status_word;

    assign accept    = iCMD_VALID & ready_q;
    assign is_push   = accept & (iCMD_OP == OP_PUSH);
    assign is_rdl    = accept & (iCMD_OP == OP_RDL);
    assign is_wrl    = accept & (iCMD_OP == OP_WRL);
    assign is_wrg    = accept & (iCMD_OP == OP_WRG);
    assign is_flush  = accept & (iCMD_OP == OP_FLUSH);
    assign is_status = accept & (iCMD_OP == OP_STATUS);
    assign is_clrerr = accept & (iCMD_OP == OP_CLRERR);
    assign is_bad    = accept & (iCMD_OP > OP_CLRERR);

    gppcu_fwft_fifo #(
        .DATA_W       (DATA_W),
        .DEPTH_LOG2   (DEPTH_LOG2),
        .AFULL_MARGIN (AFULL_MARGIN)
    ) u_fifo (
        .opclk (opclk),
        .inRST (inRST),
        .push  (is_push),
        .wdata (iDATA),
        .pop   (oINSTR_VALID & iINSTR_READY),
        .flush (is_flush),
        .rdata (oINSTR),
        .level (oLEVEL),
        .full  (oFULL),
        .empty (oEMPTY),
        .afull (oALMOST_FULL),
        .ovf   (fifo_ovf)
    );

    assign oINSTR_VALID = ~oEMPTY;

    always_comb begin
        status_word                   = '0;
        status_word[ST_OVF_BIT]       = ovf_q;
        status_word[ST_BADCMD_BIT]    = badcmd_q;
        status_word[ST_FULL_BIT]      = oFULL;
        status_word[ST_EMPTY_BIT]     = oEMPTY;
        status_word[DEPTH_LOG2:0]     = oLEVEL;
    end

    // Read FSM; RD_DONE decodes a new command exactly as IDLE does.
    always_ff @(posedge opclk or negedge inRST) begin
        if (!inRST) begin
            state_q      <= StIdle;
            ready_q      <= 1'b1;
            lmem_rd_q    <= 1'b0;
            data_valid_q <= 1'b0;
            data_q       <= '0;
        end else begin
            lmem_rd_q    <= 1'b0;
            data_valid_q <= 1'b0;
            case (state_q)
                StIdle, StRdDone: begin
                    state_q <= StIdle;
                    ready_q <= 1'b1;
                    if (is_rdl) begin
                        state_q   <= StRdIssue;
                        ready_q   <= 1'b0;
                        lmem_rd_q <= 1'b1;
                    end else if (is_status) begin
                        state_q      <= StRdDone;
                        data_q       <= status_word;
                        data_valid_q <= 1'b1;
                    end
                end
                StRdIssue: begin
                    state_q <= StRdWait;
                    ready_q <= 1'b0;
                end
                StRdWait: begin
                    state_q      <= StRdDone;
                    ready_q      <= 1'b1;
                    data_q       <= iLMEM_RDATA;
                    data_valid_q <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Memory ports and sticky errors; a new error in the CLRERR cycle keeps the flag set.
    always_ff @(posedge opclk or negedge inRST) begin
        if (!inRST) begin
            oLMEM_THREAD <= '0;
            oLMEM_ADDR   <= '0;
            oLMEM_WDATA  <= '0;
            oGMEM_ADDR   <= '0;
            oGMEM_WDATA  <= '0;
            lmem_wr_q    <= 1'b0;
            gmem_wr_q    <= 1'b0;
            ovf_q        <= 1'b0;
            badcmd_q     <= 1'b0;
        end else begin
            if (is_rdl | is_wrl) begin
                oLMEM_THREAD <= iCMD_THREAD;
                oLMEM_ADDR   <= iCMD_ADDR;
            end
            if (is_wrl) oLMEM_WDATA <= iDATA;
            if (is_wrg) begin
                oGMEM_ADDR  <= iCMD_ADDR;
                oGMEM_WDATA <= iDATA;
            end
            lmem_wr_q <= is_wrl;
            gmem_wr_q <= is_wrg;
            if (fifo_ovf)       ovf_q <= 1'b1;
            else if (is_clrerr) ovf_q <= 1'b0;
            if (is_bad)         badcmd_q <= 1'b1;
            else if (is_clrerr) badcmd_q <= 1'b0;
        end
    end

    assign oCMD_READY  = ready_q;
    assign oLMEM_RD    = lmem_rd_q;
    assign oLMEM_WR    = lmem_wr_q;
    assign oGMEM_WR    = gmem_wr_q;
    assign oDATA       = data_q;
    assign oDATA_VALID = data_valid_q;
    assign oERR_OVF    = ovf_q;
    assign oERR_BADCMD = badcmd_q;

endmodule

// File: tb/tb_gppcu_cmd_frontend.sv
// tb_gppcu_cmd_frontend: directed self-checking bench for gppcu_cmd_frontend.
// Two instances share all inputs: a default 256-deep one and a 4-deep one (AFULL_MARGIN 1)
// for full/overflow behaviour. Inputs are driven and outputs sampled on the falling edge.
module tb_gppcu_cmd_frontend;
    import gppcu_cmd_pkg::*;

    logic        opclk = 1'b0;
    logic        inRST = 1'b1;
    logic        iCMD_VALID = 1'b0;
    logic [6:0]  iCMD_OP = '0;
    logic [7:0]  iCMD_THREAD = '0;
    logic [15:0] iCMD_ADDR = '0;
    logic [31:0] iDATA = '0;
    logic        iINSTR_READY = 1'b0;
    logic [31:0] iLMEM_RDATA = '0;

    logic        oCMD_READY, oINSTR_VALID, oFULL, oALMOST_FULL, oEMPTY, oERR_OVF, oERR_BADCMD;
    logic        oLMEM_RD, oLMEM_WR, oGMEM_WR, oDATA_VALID;
    logic [31:0] oINSTR, oLMEM_WDATA, oGMEM_WDATA, oDATA;
    logic [8:0]  oLEVEL;
    logic [7:0]  oLMEM_THREAD;
    logic [15:0] oLMEM_ADDR, oGMEM_ADDR;

    logic        s_oCMD_READY, s_oINSTR_VALID, s_oFULL, s_oALMOST_FULL, s_oEMPTY;
    logic        s_oERR_OVF, s_oERR_BADCMD;
    logic        s_oLMEM_RD, s_oLMEM_WR, s_oGMEM_WR, s_oDATA_VALID;
    logic [31:0] s_oINSTR, s_oLMEM_WDATA, s_oGMEM_WDATA, s_oDATA;
    logic [2:0]  s_oLEVEL;
    logic [7:0]  s_oLMEM_THREAD;
    logic [15:0] s_oLMEM_ADDR, s_oGMEM_ADDR;

    int checks = 0;
    int failures = 0;
    logic [31:0] model_mem [16];

    always #5 opclk = ~opclk;

    // Local-memory model: read data returned one cycle after the read strobe.
    always @(posedge opclk) begin
        if (oLMEM_WR) model_mem[oLMEM_ADDR[3:0]] <= oLMEM_WDATA;
        iLMEM_RDATA <= oLMEM_RD ? model_mem[oLMEM_ADDR[3:0]] : 32'h0;
    end

    gppcu_cmd_frontend dut (
        .opclk(opclk), .inRST(inRST), .iCMD_VALID(iCMD_VALID), .iCMD_OP(iCMD_OP),
        .iCMD_THREAD(iCMD_THREAD), .iCMD_ADDR(iCMD_ADDR), .iDATA(iDATA),
        .oCMD_READY(oCMD_READY), .oINSTR(oINSTR), .oINSTR_VALID(oINSTR_VALID),
        .iINSTR_READY(iINSTR_READY), .oLEVEL(oLEVEL), .oFULL(oFULL),
        .oALMOST_FULL(oALMOST_FULL), .oEMPTY(oEMPTY), .oERR_OVF(oERR_OVF),
        .oERR_BADCMD(oERR_BADCMD), .oLMEM_THREAD(oLMEM_THREAD), .oLMEM_ADDR(oLMEM_ADDR),
        .oLMEM_WDATA(oLMEM_WDATA), .oLMEM_RD(oLMEM_RD), .oLMEM_WR(oLMEM_WR),
        .iLMEM_RDATA(iLMEM_RDATA), .oGMEM_ADDR(oGMEM_ADDR), .oGMEM_WDATA(oGMEM_WDATA),
        .oGMEM_WR(oGMEM_WR), .oDATA(oDATA), .oDATA_VALID(oDATA_VALID)
    );

    gppcu_cmd_frontend #(
        .DEPTH_LOG2   (2),
        .AFULL_MARGIN (1)
    ) dut_small (
        .opclk(opclk), .inRST(inRST), .iCMD_VALID(iCMD_VALID), .iCMD_OP(iCMD_OP),
        .iCMD_THREAD(iCMD_THREAD), .iCMD_ADDR(iCMD_ADDR), .iDATA(iDATA),
        .oCMD_READY(s_oCMD_READY), .oINSTR(s_oINSTR), .oINSTR_VALID(s_oINSTR_VALID),
        .iINSTR_READY(iINSTR_READY), .oLEVEL(s_oLEVEL), .oFULL(s_oFULL),
        .oALMOST_FULL(s_oALMOST_FULL), .oEMPTY(s_oEMPTY), .oERR_OVF(s_oERR_OVF),
        .oERR_BADCMD(s_oERR_BADCMD), .oLMEM_THREAD(s_oLMEM_THREAD),
        .oLMEM_ADDR(s_oLMEM_ADDR), .oLMEM_WDATA(s_oLMEM_WDATA), .oLMEM_RD(s_oLMEM_RD),
        .oLMEM_WR(s_oLMEM_WR), .iLMEM_RDATA(iLMEM_RDATA), .oGMEM_ADDR(s_oGMEM_ADDR),
        .oGMEM_WDATA(s_oGMEM_WDATA), .oGMEM_WR(s_oGMEM_WR), .oDATA(s_oDATA),
        .oDATA_VALID(s_oDATA_VALID)
    );

    // Present one command for one cycle; returns on the falling edge after it was accepted.
    task automatic cmd(input logic [6:0] op, input logic [7:0] thr, input logic [15:0] addr,
                       input logic [31:0] data);
        iCMD_VALID  = 1'b1;
        iCMD_OP     = op;
        iCMD_THREAD = thr;
        iCMD_ADDR   = addr;
        iDATA       = data;
        @(negedge opclk);
        iCMD_VALID  = 1'b0;
    endtask

    task automatic test_reset();
        #2 inRST = 1'b0;
        repeat (2) @(negedge opclk);
        checks++;
        if ({oCMD_READY, oEMPTY, oFULL, oALMOST_FULL, oINSTR_VALID, oERR_OVF, oERR_BADCMD,
             oLMEM_RD, oLMEM_WR, oGMEM_WR, oDATA_VALID} !== 11'b11000000000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=11000000000", {oCMD_READY, oEMPTY, oFULL,
                     oALMOST_FULL, oINSTR_VALID, oERR_OVF, oERR_BADCMD, oLMEM_RD, oLMEM_WR,
                     oGMEM_WR, oDATA_VALID});
        end
        checks++;
        if ({oLEVEL, oDATA, oLMEM_THREAD, oLMEM_ADDR, oLMEM_WDATA, oGMEM_ADDR, oGMEM_WDATA}
            !== '0) begin
            failures++;
            $display("FAIL reset_values level=%0d data=%h lmem_addr=%h", oLEVEL, oDATA,
                     oLMEM_ADDR);
        end
        checks++;
        if ({s_oCMD_READY, s_oEMPTY, s_oFULL, s_oALMOST_FULL, s_oINSTR_VALID} !== 5'b11000) begin
            failures++;
            $display("FAIL reset_small got=%b exp=11000", {s_oCMD_READY, s_oEMPTY, s_oFULL,
                     s_oALMOST_FULL, s_oINSTR_VALID});
        end
        inRST = 1'b1;
        @(negedge opclk);
    endtask

    task automatic test_fifo_order();
        iINSTR_READY = 1'b0;
        for (int i = 0; i < 4; i++) cmd(OP_PUSH, 8'd0, 16'd0, 32'hA0 + i);
        checks++;
        if ({oLEVEL, oINSTR_VALID, oINSTR} !== {9'd4, 1'b1, 32'hA0}) begin
            failures++;
            $display("FAIL order_fill level=%0d instr=%h exp level=4 instr=a0", oLEVEL, oINSTR);
        end
        iINSTR_READY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (oINSTR !== 32'hA0 + i) begin
                failures++;
                $display("FAIL order_pop%0d got=%h exp=%h", i, oINSTR, 32'hA0 + i);
            end
            @(negedge opclk);
        end
        iINSTR_READY = 1'b0;
        checks++;
        if ({oEMPTY, oINSTR_VALID, oLEVEL} !== {1'b1, 1'b0, 9'd0}) begin
            failures++;
            $display("FAIL order_empty empty=%b level=%0d exp empty=1 level=0", oEMPTY, oLEVEL);
        end
    endtask

    task automatic test_overflow();
        iINSTR_READY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cmd(OP_PUSH, 8'd0, 16'd0, 32'hB0 + i);
            checks++;
            if (s_oALMOST_FULL !== (i >= 2)) begin
                failures++;
                $display("FAIL afull_level%0d got=%b exp=%b", i + 1, s_oALMOST_FULL, i >= 2);
            end
        end
        checks++;
        if ({s_oFULL, s_oLEVEL, s_oERR_OVF} !== {1'b1, 3'd4, 1'b0}) begin
            failures++;
            $display("FAIL full got full=%b level=%0d ovf=%b exp 1/4/0", s_oFULL, s_oLEVEL,
                     s_oERR_OVF);
        end
        iINSTR_READY = 1'b1;
        cmd(OP_PUSH, 8'd0, 16'd0, 32'hB4);
        iINSTR_READY = 1'b0;
        checks++;
        if ({s_oERR_OVF, s_oLEVEL, s_oINSTR} !== {1'b1, 3'd3, 32'hB1}) begin
            failures++;
            $display("FAIL ovf_drop got ovf=%b level=%0d head=%h exp 1/3/b1", s_oERR_OVF,
                     s_oLEVEL, s_oINSTR);
        end
        checks++;
        if ({oERR_OVF, oLEVEL} !== {1'b0, 9'd4}) begin
            failures++;
            $display("FAIL big_no_ovf got ovf=%b level=%0d exp 0/4", oERR_OVF, oLEVEL);
        end
        cmd(OP_CLRERR, 8'd0, 16'd0, 32'd0);
        checks++;
        if (s_oERR_OVF !== 1'b0) begin
            failures++;
            $display("FAIL clrerr_ovf got=%b exp=0", s_oERR_OVF);
        end
        cmd(OP_FLUSH, 8'd0, 16'd0, 32'd0);
        checks++;
        if ({oLEVEL, s_oLEVEL} !== {9'd0, 3'd0}) begin
            failures++;
            $display("FAIL ovf_flush got big=%0d small=%0d exp 0/0", oLEVEL, s_oLEVEL);
        end
    endtask

    task automatic test_stream();
        iINSTR_READY = 1'b0;
        for (int i = 0; i < 3; i++) cmd(OP_PUSH, 8'd0, 16'd0, 32'h1000 + i);
        iINSTR_READY = 1'b1;
        iCMD_VALID   = 1'b1;
        iCMD_OP      = OP_PUSH;
        for (int k = 0; k < 600; k++) begin
            iDATA = 32'h1000 + 3 + k;
            checks++;
            if ({oLEVEL, oINSTR} !== {9'd3, 32'h1000 + k}) begin
                failures++;
                $display("FAIL stream%0d got level=%0d head=%h exp 3/%h", k, oLEVEL, oINSTR,
                         32'h1000 + k);
            end
            @(negedge opclk);
        end
        iCMD_VALID   = 1'b0;
        iINSTR_READY = 1'b0;
        checks++;
        if ({oLEVEL, oINSTR} !== {9'd3, 32'h1000 + 600}) begin
            failures++;
            $display("FAIL stream_end got level=%0d head=%h exp 3/%h", oLEVEL, oINSTR,
                     32'h1000 + 600);
        end
        cmd(OP_FLUSH, 8'd0, 16'd0, 32'd0);
    endtask

    task automatic test_lmem_rw();
        cmd(OP_WRL, 8'd5, 16'h0012, 32'hDEADBEEF);
        checks++;
        if ({oLMEM_WR, oLMEM_RD, oLMEM_THREAD, oLMEM_ADDR, oLMEM_WDATA} !==
            {1'b1, 1'b0, 8'd5, 16'h0012, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL wrl_pulse got wr=%b thr=%0d addr=%h data=%h", oLMEM_WR,
                     oLMEM_THREAD, oLMEM_ADDR, oLMEM_WDATA);
        end
        @(negedge opclk);
        checks++;
        if (oLMEM_WR !== 1'b0) begin
            failures++;
            $display("FAIL wrl_one_cycle got=%b exp=0", oLMEM_WR);
        end
        cmd(OP_WRG, 8'd0, 16'h0034, 32'hCAFEF00D);
        checks++;
        if ({oGMEM_WR, oGMEM_ADDR, oGMEM_WDATA} !== {1'b1, 16'h0034, 32'hCAFEF00D}) begin
            failures++;
            $display("FAIL wrg_pulse got wr=%b addr=%h data=%h", oGMEM_WR, oGMEM_ADDR,
                     oGMEM_WDATA);
        end
        @(negedge opclk);
        checks++;
        if (oGMEM_WR !== 1'b0) begin
            failures++;
            $display("FAIL wrg_one_cycle got=%b exp=0", oGMEM_WR);
        end
        // RDL accepted at N; a PUSH offered while busy must be ignored.
        cmd(OP_RDL, 8'd5, 16'h0012, 32'd0);
        iCMD_VALID = 1'b1;
        iCMD_OP    = OP_PUSH;
        iDATA      = 32'h55;
        checks++;
        if ({oCMD_READY, oLMEM_RD, oDATA_VALID} !== 3'b010) begin
            failures++;
            $display("FAIL rdl_n1 got rdy/rd/dv=%b exp=010", {oCMD_READY, oLMEM_RD, oDATA_VALID});
        end
        @(negedge opclk);
        iCMD_VALID = 1'b0;
        checks++;
        if ({oCMD_READY, oLMEM_RD, oDATA_VALID} !== 3'b000) begin
            failures++;
            $display("FAIL rdl_n2 got rdy/rd/dv=%b exp=000", {oCMD_READY, oLMEM_RD, oDATA_VALID});
        end
        @(negedge opclk);
        checks++;
        if ({oCMD_READY, oLMEM_RD, oDATA_VALID, oDATA} !== {3'b101, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL rdl_n3 got rdy/rd/dv=%b data=%h exp 101/deadbeef",
                     {oCMD_READY, oLMEM_RD, oDATA_VALID}, oDATA);
        end
        // STATUS accepted in RD_DONE: empty FIFO, no errors.
        cmd(OP_STATUS, 8'd0, 16'd0, 32'd0);
        checks++;
        if ({oDATA_VALID, oDATA} !== {1'b1, 32'h10000000}) begin
            failures++;
            $display("FAIL status_in_done got dv=%b data=%h exp 1/10000000", oDATA_VALID, oDATA);
        end
        @(negedge opclk);
        checks++;
        if ({oDATA_VALID, oDATA} !== {1'b0, 32'h10000000}) begin
            failures++;
            $display("FAIL data_hold got dv=%b data=%h exp 0/10000000", oDATA_VALID, oDATA);
        end
    endtask

    task automatic test_badcmd_status();
        cmd(7'd9, 8'd0, 16'd0, 32'd0);
        checks++;
        if ({oERR_BADCMD, oLEVEL, oLMEM_WR, oGMEM_WR, oDATA_VALID} !== {1'b1, 9'd0, 3'b000})
        begin
            failures++;
            $display("FAIL badcmd9 got bad=%b level=%0d exp 1/0", oERR_BADCMD, oLEVEL);
        end
        for (int i = 0; i < 3; i++) cmd(OP_PUSH, 8'd0, 16'd0, 32'hC0 + i);
        cmd(OP_STATUS, 8'd0, 16'd0, 32'd0);
        checks++;
        if ({oDATA_VALID, oDATA} !== {1'b1, 32'h40000003}) begin
            failures++;
            $display("FAIL status_word got dv=%b data=%h exp 1/40000003", oDATA_VALID, oDATA);
        end
        cmd(OP_CLRERR, 8'd0, 16'd0, 32'd0);
        checks++;
        if ({oERR_BADCMD, oDATA_VALID} !== 2'b00) begin
            failures++;
            $display("FAIL clrerr_bad got bad=%b dv=%b exp 0/0", oERR_BADCMD, oDATA_VALID);
        end
        cmd(7'd7, 8'd0, 16'd0, 32'd0);
        checks++;
        if (oERR_BADCMD !== 1'b1) begin
            failures++;
            $display("FAIL badcmd7 got=%b exp=1", oERR_BADCMD);
        end
        cmd(OP_CLRERR, 8'd0, 16'd0, 32'd0);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 2; i++) cmd(OP_PUSH, 8'd0, 16'd0, 32'hC3 + i);
        checks++;
        if (oLEVEL !== 9'd5) begin
            failures++;
            $display("FAIL flush_pre got level=%0d exp=5", oLEVEL);
        end
        iINSTR_READY = 1'b1;
        cmd(OP_FLUSH, 8'd0, 16'd0, 32'd0);
        iINSTR_READY = 1'b0;
        checks++;
        if ({oLEVEL, oINSTR_VALID, oEMPTY} !== {9'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL flush got level=%0d valid=%b empty=%b exp 0/0/1", oLEVEL,
                     oINSTR_VALID, oEMPTY);
        end
        cmd(OP_PUSH, 8'd0, 16'd0, 32'hD0);
        checks++;
        if ({oLEVEL, oINSTR} !== {9'd1, 32'hD0}) begin
            failures++;
            $display("FAIL after_flush got level=%0d head=%h exp 1/d0", oLEVEL, oINSTR);
        end
    endtask

    task automatic test_reset_midread();
        cmd(OP_RDL, 8'd3, 16'h0007, 32'd0);
        @(negedge opclk);
        checks++;
        if (oCMD_READY !== 1'b0) begin
            failures++;
            $display("FAIL rd_wait_busy got=%b exp=0", oCMD_READY);
        end
        inRST = 1'b0;
        #1;
        checks++;
        if ({oCMD_READY, oEMPTY, oFULL, oALMOST_FULL, oINSTR_VALID, oERR_OVF, oERR_BADCMD,
             oLMEM_RD, oLMEM_WR, oGMEM_WR, oDATA_VALID} !== 11'b11000000000) begin
            failures++;
            $display("FAIL midreset_flags got=%b exp=11000000000", {oCMD_READY, oEMPTY, oFULL,
                     oALMOST_FULL, oINSTR_VALID, oERR_OVF, oERR_BADCMD, oLMEM_RD, oLMEM_WR,
                     oGMEM_WR, oDATA_VALID});
        end
        checks++;
        if ({oLEVEL, oDATA, oLMEM_THREAD, oLMEM_ADDR, oLMEM_WDATA, oGMEM_ADDR, oGMEM_WDATA}
            !== '0) begin
            failures++;
            $display("FAIL midreset_values level=%0d data=%h lmem_addr=%h gmem_addr=%h", oLEVEL,
                     oDATA, oLMEM_ADDR, oGMEM_ADDR);
        end
        @(negedge opclk);
        inRST = 1'b1;
        repeat (3) @(negedge opclk);
        checks++;
        if ({oCMD_READY, oDATA_VALID, oLMEM_RD} !== 3'b100) begin
            failures++;
            $display("FAIL post_reset_idle got rdy/dv/rd=%b exp=100",
                     {oCMD_READY, oDATA_VALID, oLMEM_RD});
        end
    endtask

    initial begin
        test_reset();
        test_fifo_order();
        test_overflow();
        test_stream();
        test_lmem_rw();
        test_badcmd_status();
        test_flush();
        test_reset_midread();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
